// File: rtl/syn_but_sched.sv
// syn_but_sched
//   Master-side scheduler for the radix-2 butterfly unit. Runs a complete
//   in-place decimation-in-time FFT over the sample RAM. The RAM already holds
//   the input in bit-reversed order. The block walks every stage, fetches each
//   operand pair plus its twiddle, and strobes them into the butterfly. It then
//   writes the two result beats back to the operand addresses.
//
//   Ports
//     clk_ir, rst_sync_l        clock, asynchronous active-low reset
//     fft_start                 start pulse (ignored unless idle)
//     fft_busy / fft_done       run status / one-cycle completion pulse
//     but_err                   sticky error, cleared by an accepted start
//     ram_rd_*                  sample RAM read port (data P_RD_LAT after enable)
//     ram_wr_*                  sample RAM write port (driven from result beats)
//     twdl_addr / twdl_data     twiddle ROM (data P_RD_LAT after address)
//     but_sample_a/b, but_twdl  butterfly operands, held between strobes
//     but_sample_rdy            operand strobe
//     but_res, but_res_rdy      butterfly result beats (sum first, then difference)
//     but_bffr_ovrflw/underflw  butterfly buffer fault indications
//     dbg_state                 current FSM state
//
//   Handshake: both directions are valid-only with no back-pressure.
//   but_sample_rdy is high for exactly one cycle per butterfly, and operands are
//   valid in that cycle. Each but_res_rdy cycle carries one result beat that
//   must be consumed in that same cycle. Flow control comes from throttling
//   issue on the pending write-back queue.
module syn_but_sched #(
    parameter int P_LOG2N    = 7,
    parameter int P_SAMPLE_W = 32,
    parameter int P_TWDL_W   = 10,
    parameter int P_RD_LAT   = 2,
    parameter int P_Q_DEPTH  = 8
) (
    input  logic                    clk_ir,
    input  logic                    rst_sync_l,
    input  logic                    fft_start,
    output logic                    fft_busy,
    output logic                    fft_done,
    output logic                    but_err,
    output logic [P_LOG2N-1:0]      ram_rd_addr,
    output logic                    ram_rd_en,
    input  logic [2*P_SAMPLE_W-1:0] ram_rd_data,
    output logic [P_LOG2N-1:0]      ram_wr_addr,
    output logic                    ram_wr_en,
    output logic [2*P_SAMPLE_W-1:0] ram_wr_data,
    output logic [P_LOG2N-2:0]      twdl_addr,
    input  logic [2*P_TWDL_W-1:0]   twdl_data,
    output logic [2*P_SAMPLE_W-1:0] but_sample_a,
    output logic [2*P_SAMPLE_W-1:0] but_sample_b,
    output logic [2*P_TWDL_W-1:0]   but_twdl,
    output logic                    but_sample_rdy,
    input  logic [2*P_SAMPLE_W-1:0] but_res,
    input  logic                    but_res_rdy,
    input  logic                    but_bffr_ovrflw,
    input  logic                    but_bffr_underflw,
    output logic [1:0]              dbg_state
);
    localparam int LW  = P_LOG2N;
    localparam int JW  = P_LOG2N - 1;
    localparam int SW  = $clog2(P_LOG2N);
    localparam int DW  = 2 * P_SAMPLE_W;
    localparam int TW  = 2 * P_TWDL_W;
    localparam int QAW = $clog2(P_Q_DEPTH);
    localparam int QCW = QAW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [JW-1:0]     j_q, j_d;
    logic              phase_q, phase_d;   // 0: a-read slot cycle, 1: b-read cycle
    logic              err_q, err_d;
    logic              beat_q;             // 1 once the sum beat of the head entry is written
    logic [QAW-1:0]    q_wptr_q, q_rptr_q;
    logic [QCW-1:0]    q_cnt_q;
    logic [2*LW-1:0]   q_mem [P_Q_DEPTH];
    logic [P_RD_LAT-1:0] rd_vld_q, rd_isb_q;
    logic [DW-1:0]     a_hold_q, sa_q, sb_q;
    logic [TW-1:0]     tw_q;
    logic              rdy_q;

    logic              push, pop, res_ok, q_full, q_empty;
    logic              rd_en, rd_is_b, start_ok, done;
    logic [JW-1:0]     mask_j;
    logic [LW-1:0]     span, addr_a, addr_b;
    logic [JW-1:0]     tw_idx;
    logic [2*LW-1:0]   head;
    logic              cap_vld, cap_b;

    // Low s bits of j index the butterfly within its group; the high bits pick
    // the group, which is spread out by one extra bit to make room for the
    // partner at +span.
    always_comb begin
        mask_j = ~({JW{1'b1}} << stage_q);
        span   = {{(LW-1){1'b0}}, 1'b1} << stage_q;
        addr_a = {j_q & ~mask_j, 1'b0} | {1'b0, j_q & mask_j};
        addr_b = addr_a | span;
        tw_idx = (j_q & mask_j) << (SW'(JW) - stage_q);
    end

    assign q_full  = (q_cnt_q == QCW'(P_Q_DEPTH));
    assign q_empty = (q_cnt_q == '0);
    assign res_ok  = but_res_rdy && !q_empty;
    assign pop     = res_ok && beat_q;
    assign head    = q_mem[q_rptr_q];

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        j_d      = j_q;
        phase_d  = phase_q;
        push     = 1'b0;
        rd_en    = 1'b0;
        rd_is_b  = 1'b0;
        start_ok = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fft_start) begin
                    start_ok = 1'b1;
                    state_d  = ST_ISSUE;
                    stage_d  = '0;
                    j_d      = '0;
                    phase_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (!phase_q) begin
                    // A slot only opens when the write-back queue has room.
                    if (!q_full) begin
                        rd_en   = 1'b1;
                        push    = 1'b1;
                        phase_d = 1'b1;
                    end
                end else begin
                    rd_en   = 1'b1;
                    rd_is_b = 1'b1;
                    phase_d = 1'b0;
                    if (j_q == {JW{1'b1}}) state_d = ST_DRAIN;
                    else                   j_d     = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The next stage reads what this stage writes, so every result
                // must have landed first.
                if (q_empty && !beat_q) begin
                    if (stage_q == SW'(P_LOG2N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        j_d     = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (start_ok) err_d = 1'b0;
        if (but_bffr_ovrflw || but_bffr_underflw || (but_res_rdy && q_empty)) err_d = 1'b1;
    end

    assign cap_vld = rd_vld_q[P_RD_LAT-1];
    assign cap_b   = rd_isb_q[P_RD_LAT-1];

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q  <= ST_IDLE;
            stage_q  <= '0;
            j_q      <= '0;
            phase_q  <= 1'b0;
            err_q    <= 1'b0;
            beat_q   <= 1'b0;
            q_wptr_q <= '0;
            q_rptr_q <= '0;
            q_cnt_q  <= '0;
            rd_vld_q <= '0;
            rd_isb_q <= '0;
            a_hold_q <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            tw_q     <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            // Toggle per accepted beat; the second beat pops and returns it to 0.
            if (res_ok) beat_q <= !beat_q;
            if (push) q_wptr_q <= q_wptr_q + 1'b1;
            if (pop)  q_rptr_q <= q_rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   q_cnt_q <= q_cnt_q + 1'b1;
                2'b01:   q_cnt_q <= q_cnt_q - 1'b1;
                default: q_cnt_q <= q_cnt_q;
            endcase
            // Tag each read so its data is recognised P_RD_LAT cycles later.
            rd_vld_q[0] <= rd_en;
            rd_isb_q[0] <= rd_is_b;
            for (int i = 1; i < P_RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_isb_q[i] <= rd_isb_q[i-1];
            end
            if (cap_vld && !cap_b) a_hold_q <= ram_rd_data;
            if (cap_vld && cap_b) begin
                sa_q <= a_hold_q;
                sb_q <= ram_rd_data;
                tw_q <= twdl_data;
            end
            rdy_q <= cap_vld && cap_b;
        end
    end

    always_ff @(posedge clk_ir) begin
        if (push) q_mem[q_wptr_q] <= {addr_a, addr_b};
    end

    assign fft_busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign fft_done       = done;
    assign but_err        = err_q;
    assign dbg_state      = state_q;
    assign ram_rd_en      = rd_en;
    assign ram_rd_addr    = rd_is_b ? addr_b : (rd_en ? addr_a : '0);
    assign twdl_addr      = rd_is_b ? tw_idx : '0;
    // Beats with no pending entry are flagged as errors and never written.
    assign ram_wr_en      = res_ok;
    assign ram_wr_addr    = res_ok ? (beat_q ? head[LW-1:0] : head[2*LW-1:LW]) : '0;
    assign ram_wr_data    = res_ok ? but_res : '0;
    assign but_sample_a   = sa_q;
    assign but_sample_b   = sb_q;
    assign but_twdl       = tw_q;
    assign but_sample_rdy = rdy_q;
endmodule

// File: tb/tb_syn_but_sched.sv
// tb_syn_but_sched
//   Bench for syn_but_sched at N=32 with a 4-deep write-back queue. The bench
//   provides:
//     - a sample RAM model,
//     - a twiddle ROM model,
//     - a butterfly model with a programmable latency,
//     - a group/offset loop reference of the in-place transform.
module tb_syn_but_sched;
    localparam int LW  = 5;
    localparam int N   = 1 << LW;
    localparam int TAW = LW - 1;
    localparam int W   = 32;
    localparam int TWH = 10;
    localparam int LAT = 2;
    localparam int QD  = 4;
    localparam int DW  = 2 * W;
    localparam int TWW = 2 * TWH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            fft_start, fft_busy, fft_done, but_err;
    logic [LW-1:0]   ram_rd_addr, ram_wr_addr;
    logic            ram_rd_en, ram_wr_en;
    logic [DW-1:0]   ram_rd_data, ram_wr_data;
    logic [TAW-1:0]  twdl_addr;
    logic [TWW-1:0]  twdl_data, but_twdl;
    logic [DW-1:0]   but_sample_a, but_sample_b, but_res;
    logic            but_sample_rdy, but_res_rdy, ovr, und;
    logic [1:0]      dbg_state;

    syn_but_sched #(.P_LOG2N(LW), .P_SAMPLE_W(W), .P_TWDL_W(TWH), .P_RD_LAT(LAT), .P_Q_DEPTH(QD)) dut (
        .clk_ir(clk), .rst_sync_l(rst_n), .fft_start(fft_start), .fft_busy(fft_busy),
        .fft_done(fft_done), .but_err(but_err), .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en),
        .ram_rd_data(ram_rd_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
        .ram_wr_data(ram_wr_data), .twdl_addr(twdl_addr), .twdl_data(twdl_data),
        .but_sample_a(but_sample_a), .but_sample_b(but_sample_b), .but_twdl(but_twdl),
        .but_sample_rdy(but_sample_rdy), .but_res(but_res), .but_res_rdy(but_res_rdy),
        .but_bffr_ovrflw(ovr), .but_bffr_underflw(und), .dbg_state(dbg_state)
    );

    function automatic logic [TWW-1:0] tw_rom(input logic [TAW-1:0] i);
        return {TWH'(i * 37 + 5), TWH'(i * 11 + 3)};
    endfunction

    // Butterfly: sum and difference of a with (b offset by the twiddle).
    function automatic logic [2*DW-1:0] bfly(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [TWW-1:0] w);
        logic [W-1:0] mr, mi;
        mr = b[DW-1:W] + W'(w[TWW-1:TWH]);
        mi = b[W-1:0] + W'(w[TWH-1:0]);
        return {a[DW-1:W] + mr, a[W-1:0] + mi, a[DW-1:W] - mr, a[W-1:0] - mi};
    endfunction

    // ---------------- sample RAM / twiddle ROM models ----------------
    logic [DW-1:0]  mem [N];
    logic [DW-1:0]  rd_pipe [LAT];
    logic [TWW-1:0] tw_pipe [LAT];
    logic           ld_en = 1'b0;
    logic [LW-1:0]  ld_addr = '0;
    logic [DW-1:0]  ld_data = '0;

    always @(posedge clk) begin
        rd_pipe[0] <= ram_rd_en ? mem[ram_rd_addr] : '0;
        tw_pipe[0] <= tw_rom(twdl_addr);
        for (int i = 1; i < LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            tw_pipe[i] <= tw_pipe[i-1];
        end
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end
    assign ram_rd_data = rd_pipe[LAT-1];
    assign twdl_data   = tw_pipe[LAT-1];

    // ---------------- butterfly model ----------------
    int unsigned     cyc = 0;
    int unsigned     lat = 1;
    logic [2*DW-1:0] job_q [$];
    int unsigned     job_t [$];
    logic            second, mdl_rdy, inj_rdy;
    logic [DW-1:0]   mdl_res, diff_hold;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_q.delete();
            job_t.delete();
            second  <= 1'b0;
            mdl_rdy <= 1'b0;
            mdl_res <= '0;
        end else begin
            if (but_sample_rdy) begin
                job_q.push_back(bfly(but_sample_a, but_sample_b, but_twdl));
                job_t.push_back(cyc + lat);
            end
            if (second) begin
                mdl_rdy <= 1'b1;
                mdl_res <= diff_hold;
                second  <= 1'b0;
            end else if (job_q.size() > 0 && job_t[0] <= cyc) begin
                mdl_rdy   <= 1'b1;
                mdl_res   <= job_q[0][2*DW-1:DW];
                diff_hold <= job_q[0][DW-1:0];
                second    <= 1'b1;
                void'(job_q.pop_front());
                void'(job_t.pop_front());
            end else begin
                mdl_rdy <= 1'b0;
            end
        end
    end
    assign but_res_rdy = mdl_rdy | inj_rdy;
    assign but_res     = mdl_res;

    // ---------------- monitor ----------------
    logic [LW-1:0]  rd_log_a [$];
    logic [TAW-1:0] rd_log_t [$];
    int   rd_n, pend, max_pend, strobes, adj, done_n, done_bad;
    logic wr_beat, prev_rdy, prev_busy;
    logic clr_mon = 1'b0;

    always @(posedge clk) begin
        if (clr_mon) begin
            rd_log_a.delete(); rd_log_t.delete();
            rd_n = 0; pend = 0; max_pend = 0; strobes = 0; adj = 0; done_n = 0; done_bad = 0;
            wr_beat = 1'b0; prev_rdy = 1'b0; prev_busy = 1'b0;
        end else if (rst_n) begin
            if (ram_rd_en) begin
                rd_log_a.push_back(ram_rd_addr);
                rd_log_t.push_back(twdl_addr);
                if (rd_n % 2 == 0) pend++;
                rd_n++;
            end
            if (ram_wr_en) begin
                if (wr_beat) pend--;
                wr_beat = !wr_beat;
            end
            if (pend > max_pend) max_pend = pend;
            if (but_sample_rdy) begin
                strobes++;
                if (prev_rdy) adj++;
            end
            if (fft_done) begin
                done_n++;
                if (fft_busy || !prev_busy) done_bad++;
            end
            prev_rdy  = but_sample_rdy;
            prev_busy = fft_busy;
        end
    end

    // ---------------- scoreboard / reference ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0]  init_img [N];
    logic [DW-1:0]  ref_mem [N];
    logic [DW-1:0]  run_a_mem [N];
    logic [LW-1:0]  exp_q [$];
    logic [TAW-1:0] exp_t [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compute_ref();
        logic [2*DW-1:0] r;
        int span, a, b, w_idx;
        exp_q.delete();
        exp_t.delete();
        for (int i = 0; i < N; i++) ref_mem[i] = init_img[i];
        for (int s = 0; s < LW; s++) begin
            span = 1 << s;
            for (int base = 0; base < N; base += 2 * span) begin
                for (int k = 0; k < span; k++) begin
                    a = base + k;
                    b = a + span;
                    w_idx = k * (N / (2 * span));
                    r = bfly(ref_mem[a], ref_mem[b], tw_rom(TAW'(w_idx)));
                    ref_mem[a] = r[2*DW-1:DW];
                    ref_mem[b] = r[DW-1:0];
                    exp_q.push_back(LW'(a));
                    exp_q.push_back(LW'(b));
                    exp_t.push_back(TAW'(w_idx));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic new_image();
        for (int i = 0; i < N; i++) init_img[i] = {$urandom, $urandom};
    endtask

    task automatic load_mem();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = LW'(i); ld_data = init_img[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk); clr_mon = 1'b1;
        @(negedge clk); clr_mon = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk); fft_start = 1'b1;
        @(negedge clk); fft_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (fft_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(fft_done), 64'd1);
    endtask

    task automatic check_mem_ref(input string tag);
        for (int i = 0; i < N; i++) chk(tag, mem[i], ref_mem[i]);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 64'({fft_busy, fft_done, but_err, ram_rd_en, ram_wr_en, but_sample_rdy,
                               dbg_state, ram_rd_addr, ram_wr_addr, twdl_addr}), 64'd0);
        chk({tag, "_sa"}, but_sample_a, 64'd0);
        chk({tag, "_sb"}, but_sample_b, 64'd0);
        chk({tag, "_wd"}, ram_wr_data, 64'd0);
        chk({tag, "_tw"}, 64'(but_twdl), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        fft_start = 1'b0; ovr = 1'b0; und = 1'b0; inj_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Run A: short butterfly latency, full read-sequence and result check.
        lat = 1;
        new_image(); load_mem(); compute_ref(); clear_mon();
        start_pulse();
        chk("busy_after_start", 64'(fft_busy), 64'd1);
        wait_done("done_a", 5000);
        repeat (3) @(negedge clk);
        chk("done_count_a", 64'(done_n), 64'd1);
        chk("done_busy_a", 64'(done_bad), 64'd0);
        chk("busy_idle_a", 64'(fft_busy), 64'd0);
        chk("adjacent_rdy_a", 64'(adj), 64'd0);
        chk("strobes_a", 64'(strobes), 64'(LW * N / 2));
        chk("reads_a", 64'(rd_log_a.size()), 64'(exp_q.size()));
        for (int i = 0; i < rd_log_a.size() && i < exp_q.size(); i++) begin
            chk("rd_addr", 64'(rd_log_a[i]), 64'(exp_q[i]));
            if (i % 2 == 1) chk("twdl_addr", 64'(rd_log_t[i]), 64'(exp_t[i/2]));
        end
        check_mem_ref("result_a");
        chk("err_a", 64'(but_err), 64'd0);
        for (int i = 0; i < N; i++) run_a_mem[i] = mem[i];

        // Run B: same image, long butterfly latency so the queue fills.
        lat = 40;
        load_mem(); clear_mon();
        start_pulse();
        wait_done("done_b", 20000);
        repeat (3) @(negedge clk);
        chk("max_pending_b", 64'(max_pend), 64'(QD));
        chk("adjacent_rdy_b", 64'(adj), 64'd0);
        chk("done_count_b", 64'(done_n), 64'd1);
        for (int i = 0; i < N; i++) chk("result_b", mem[i], run_a_mem[i]);

        // Run C: overflow mid-stage, start while busy, start during done.
        lat = 3;
        new_image(); load_mem(); compute_ref(); clear_mon();
        start_pulse();
        repeat ($urandom_range(20, 40)) @(negedge clk);
        ovr = 1'b1;
        @(negedge clk); ovr = 1'b0;
        chk("err_set_c", 64'(but_err), 64'd1);
        repeat ($urandom_range(5, 30)) @(negedge clk);
        start_pulse();
        chk("busy_ignore_start_c", 64'(fft_busy), 64'd1);
        wait_done("done_c", 5000);
        fft_start = 1'b1;
        @(negedge clk); fft_start = 1'b0;
        chk("start_at_done_ignored", 64'(fft_busy), 64'd0);
        repeat (20) @(negedge clk);
        chk("busy_stays_low_c", 64'(fft_busy), 64'd0);
        chk("done_count_c", 64'(done_n), 64'd1);
        chk("strobes_c", 64'(strobes), 64'(LW * N / 2));
        chk("err_sticky_c", 64'(but_err), 64'd1);
        check_mem_ref("result_c");

        // Run D: reset during stage 1, then late beat, then full recovery run.
        lat = 2;
        new_image(); load_mem(); compute_ref(); clear_mon();
        start_pulse();
        chk("err_cleared_d", 64'(but_err), 64'd0);
        repeat (65) @(negedge clk);
        chk("busy_mid_d", 64'(fft_busy), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); inj_rdy = 1'b1;
        #1 chk("late_beat_no_write", 64'(ram_wr_en), 64'd0);
        @(negedge clk); inj_rdy = 1'b0;
        chk("late_beat_err", 64'(but_err), 64'd1);

        new_image(); load_mem(); compute_ref(); clear_mon();
        start_pulse();
        chk("err_cleared_e", 64'(but_err), 64'd0);
        wait_done("done_e", 5000);
        repeat (3) @(negedge clk);
        chk("done_count_e", 64'(done_n), 64'd1);
        check_mem_ref("result_e");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/syn_but_sched.md
Name: syn_but_sched

Overview:
- Master-side scheduler for the radix-2 butterfly interface. It drives sample_a, sample_b, twiddle and sample_rdy, and consumes res and res_rdy.
- It runs a full in-place decimation-in-time FFT over a sample RAM. Input data is already in bit-reversed order, loaded by the upstream capture block.
- It sequences all stages, reads operand and twiddle memories, issues butterflies, writes results back to the same addresses, and reports completion and butterfly errors.

Parameters:
- P_LOG2N, 7, log2 of FFT points (N=128).
- P_SAMPLE_W, 32, width of each re/im field (matches syn_fft_pkg P_FFT_SAMPLE_W).
- P_TWDL_W, 10, width of each twiddle re/im field (matches P_FFT_TWDL_W).
- P_RD_LAT, 2, read latency in cycles of the sample RAM and the twiddle ROM (both equal).
- P_Q_DEPTH, 8, depth of the pending write-back address queue (power of 2).

Ports:
- clk_ir  in  1  clock
- rst_sync_l  in  1  asynchronous active-low reset
- fft_start  in  1  single-cycle start pulse; ignored while busy
- fft_busy  out  1  high from the cycle after accepted start until done
- fft_done  out  1  single-cycle completion pulse
- but_err  out  1  sticky error flag; cleared on accepted start
- ram_rd_addr  out  P_LOG2N  sample RAM read address
- ram_rd_en  out  1  sample RAM read enable
- ram_rd_data  in  2*P_SAMPLE_W  {re,im}, valid P_RD_LAT cycles after ram_rd_en
- ram_wr_addr  out  P_LOG2N  sample RAM write address
- ram_wr_en  out  1  sample RAM write enable
- ram_wr_data  out  2*P_SAMPLE_W  {re,im}
- twdl_addr  out  P_LOG2N-1  twiddle ROM address
- twdl_data  in  2*P_TWDL_W  {re,im}, valid P_RD_LAT cycles after address
- but_sample_a  out  2*P_SAMPLE_W  butterfly operand a {re,im}
- but_sample_b  out  2*P_SAMPLE_W  butterfly operand b {re,im}
- but_twdl  out  2*P_TWDL_W  butterfly twiddle {re,im}
- but_sample_rdy  out  1  one-cycle operand valid strobe
- but_res  in  2*P_SAMPLE_W  butterfly result {re,im}
- but_res_rdy  in  1  result valid; the two beats of one butterfly arrive on consecutive cycles, a-result (sum) first, then b-result (difference)
- but_bffr_ovrflw  in  1  butterfly buffer overflow
- but_bffr_underflw  in  1  butterfly buffer underflow

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; stage, butterfly counter and queue cleared.
- FSM states:
  - IDLE: on fft_start go to ISSUE; stage=0, j=0; clear but_err.
  - ISSUE: issue butterflies. After the last j of the stage has been read, go to DRAIN.
  - DRAIN: wait until the queue is empty and no write beat is outstanding. Then, if stage==P_LOG2N-1, go to DONE; else stage++, j=0, go to ISSUE.
  - DONE: pulse fft_done for 1 cycle, go to IDLE.
- fft_busy is high in ISSUE and DRAIN.
- Address generation for stage s and butterfly j (0..N/2-1):
  - span=2^s
  - addr_a=((j>>s)<<(s+1)) | (j & (span-1))
  - addr_b=addr_a+span
  - twiddle index=(j & (span-1))<<(P_LOG2N-1-s)
- Issue slot is 2 cycles:
  - Cycle t: ram_rd_addr=addr_a, rd_en=1; push {addr_a,addr_b} into the queue.
  - Cycle t+1: ram_rd_addr=addr_b, rd_en=1; twdl_addr=index.
  - Data a is captured at t+P_RD_LAT. b and the twiddle are captured at t+1+P_RD_LAT.
  - but_sample_rdy pulses at t+P_RD_LAT+2 with registered a, b and twiddle. The outputs hold their values until the next strobe.
- Maximum issue rate is one butterfly per 2 cycles, so sample_rdy is never asserted on adjacent cycles.
- A new slot does not start while queue occupancy == P_Q_DEPTH. It resumes the cycle after a pop.
- Write-back:
  - The first res_rdy beat writes ram_wr_addr=head.addr_a.
  - The second beat writes head.addr_b, then the queue head is popped.
  - ram_wr_en=but_res_rdy and ram_wr_data=but_res in the same cycle (combinational).
  - The beat toggle resets on pop.
- No RAM read-write hazard exists within a stage, because each butterfly's addresses are disjoint. DRAIN enforces ordering between stages.
- Simultaneous push and pop in one cycle leaves occupancy unchanged.
- but_err is set on but_bffr_ovrflw, but_bffr_underflw, or res_rdy with the queue empty. It stays set until the next accepted start.
- fft_start while busy is ignored. fft_start coincident with DONE is ignored.
- Reset mid-operation returns to IDLE immediately: queue and beat toggle cleared, sample_rdy and wr_en deasserted. Late res_rdy after reset sets but_err.
- Latency: with butterfly latency B (sample_rdy to first res beat), per-stage time ≈ N + P_RD_LAT + 2 + B + 2 cycles.

Test Plan:
- P_LOG2N=3, observe stage-0 reads -> read pairs (0,1), (2,3), (4,5), (6,7), all with twdl_addr=0. Stage 1 j=1 -> a=1, b=3, twdl_addr=2. Stage 2 j=3 -> a=3, b=7, twdl_addr=3.
- N=8, RAM loaded with impulse x[0]=1 (bit-reversed) and a reference butterfly model (P_MUL_LAT=3) -> all 8 bins read back 1+0j. fft_done pulses once, and fft_busy falls in the same cycle.
- Butterfly model latency 40 cycles, P_Q_DEPTH=8 -> issue stalls with 8 pending. No sample_rdy occurs on adjacent cycles, and the final RAM contents match the zero-latency run.
- Inject but_bffr_ovrflw for 1 cycle mid-stage -> but_err=1 until the next fft_start, and the FFT still completes.
- Assert rst_sync_l low during stage 1 -> all outputs 0 asynchronously. A new start after release completes a correct full FFT.
- fft_start pulsed while busy -> no restart, and exactly one fft_done for the original run.
